// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, the per-axis phase enum and the
// shared counter width used by vga_sync_gen and vga_axis_counter.
package vga_timing_pkg;

  localparam int unsigned CNT_W         = 10;
  localparam int unsigned CNT_MAX_TOTAL = 1 << CNT_W;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    FRONT   = 2'd1,
    SYNC    = 2'd2,
    BACK    = 2'd3
  } phase_e;

  // Length of one axis period (line in pixels or frame in lines).
  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned fp,
                                             input int unsigned sy, input int unsigned bp);
    return vis + fp + sy + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis -- a wrapping position counter plus the
// VISIBLE->FRONT->SYNC->BACK phase FSM. en_i advances it; wrap_o is high in the
// cycle the counter returns to 0, and feeds the next axis's en_i.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned SEG_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned SEG_FRONT   = H_FRONT_DEF,
  parameter int unsigned SEG_SYNC    = H_SYNC_DEF,
  parameter int unsigned SEG_BACK    = H_BACK_DEF
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output phase_e           phase_o,
  output logic             wrap_o
);

  localparam int unsigned TOTAL = axis_total(SEG_VISIBLE, SEG_FRONT, SEG_SYNC, SEG_BACK);

  // Last count value of each phase; the phase changes when leaving it.
  localparam logic [CNT_W-1:0] LAST_VIS   = CNT_W'(SEG_VISIBLE - 1);
  localparam logic [CNT_W-1:0] LAST_FRONT = CNT_W'(SEG_VISIBLE + SEG_FRONT - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC  = CNT_W'(SEG_VISIBLE + SEG_FRONT + SEG_SYNC - 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_e           phase_q, phase_d;

  assign wrap_o  = en_i && (cnt_q == LAST_CNT);
  assign cnt_o   = cnt_q;
  assign phase_o = phase_q;

  // Position counter next state: hold, increment, or wrap to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

  // Phase FSM next state: advances as the counter leaves each segment.
  always_comb begin
    phase_d = phase_q;
    if (en_i) begin
      unique case (phase_q)
        VISIBLE: if (cnt_q == LAST_VIS)   phase_d = FRONT;
        FRONT:   if (cnt_q == LAST_FRONT) phase_d = SYNC;
        SYNC:    if (cnt_q == LAST_SYNC)  phase_d = BACK;
        BACK:    if (cnt_q == LAST_CNT)   phase_d = VISIBLE;
        default:                          phase_d = VISIBLE;
      endcase
    end
  end

  // Counter and phase registers; clear wins over enable.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q   <= '0;
      phase_q <= VISIBLE;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA sync/timing generator. Two chained vga_axis_counter
// instances (horizontal every clock, vertical on horizontal wrap); all outputs
// are registered decodes of the counter state, one cycle behind it.
// Optional feature: define VGA_SYNC_FRAME_CNT_EN to add the 16-bit frame_count.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > CNT_MAX_TOTAL) begin : g_h_total_bad
    $error("vga_sync_gen: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > CNT_MAX_TOTAL) begin : g_v_total_bad
    $error("vga_sync_gen: V_TOTAL exceeds counter range");
  end

  // An unlocked PLL is treated exactly like reset.
  logic clr;
  assign clr = rst | ~locked;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  phase_e           h_phase, v_phase;
  logic             h_wrap;
  logic             v_wrap_unused;  // last axis in the chain, nothing consumes its wrap

  vga_axis_counter #(
    .SEG_VISIBLE(H_VISIBLE), .SEG_FRONT(H_FRONT), .SEG_SYNC(H_SYNC), .SEG_BACK(H_BACK)
  ) u_h_axis (
    .clk_i(refclk), .clr_i(clr), .en_i(1'b1),
    .cnt_o(h_cnt), .phase_o(h_phase), .wrap_o(h_wrap)
  );

  vga_axis_counter #(
    .SEG_VISIBLE(V_VISIBLE), .SEG_FRONT(V_FRONT), .SEG_SYNC(V_SYNC), .SEG_BACK(V_BACK)
  ) u_v_axis (
    .clk_i(refclk), .clr_i(clr), .en_i(h_wrap),
    .cnt_o(v_cnt), .phase_o(v_phase), .wrap_o(v_wrap_unused)
  );

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic [CNT_W-1:0] pixel_x_q, pixel_y_q;
  logic             frame_start_q, frame_start_d;

  // Decode the current counter state into next output values.
  always_comb begin
    hsync_d       = (h_phase != SYNC);
    vsync_d       = (v_phase != SYNC);
    video_on_d    = (h_phase == VISIBLE) && (v_phase == VISIBLE);
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
  end

  // Output registers; reset values are the idle (blanked, syncs high) state.
  always_ff @(posedge refclk) begin
    if (clr) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= h_cnt;
      pixel_y_q     <= v_cnt;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Count frames: bump in the cycle after each frame_start pulse, wrapping.
  always_comb begin
    frame_count_d = frame_count_q + {15'd0, frame_start_q};
  end

  // Frame counter register.
  always_ff @(posedge refclk) begin
    if (clr) frame_count_q <= '0;
    else     frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen using a reduced timing
// (30 clocks/line: 16+4+6+4, 17 lines/frame: 10+2+2+3, 510 clocks/frame) so
// that multi-frame runs stay short. Expected samples are hand-computed and
// queued with the clock index they must appear at; a monitor pops and compares.
module tb_vga_sync_gen;

  logic       refclk = 1'b0;
  logic       rst, locked;
  logic       hsync, vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  vga_sync_gen #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [9:0] x, y;
    logic       hs, vs, von, fs;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // accumulation window for per-frame totals
  int acc_lo = 1, acc_hi = 0;
  int hs_low_n = 0, vs_low_n = 0, von_n = 0, fs_n = 0, last_fs = -1;

  task automatic push(input int c, input int x, input int y,
                      input bit hs, input bit vs, input bit von, input bit fs);
    exp_t e;
    e.cyc = c; e.x = 10'(x); e.y = 10'(y);
    e.hs = hs; e.vs = vs; e.von = von; e.fs = fs;
    q.push_back(e);
  endtask

  task automatic push_rst(input int c);
    push(c, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge refclk);
  endtask

  task automatic agg(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: sample on the falling edge, compare due entries, tally totals.
  initial begin : monitor
    exp_t e;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic        fs_prev = 1'b0;
    logic [15:0] fc_prev = '0;
`endif
    forever begin
      @(negedge refclk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc < cyc ||
            pixel_x !== e.x || pixel_y !== e.y || hsync !== e.hs ||
            vsync !== e.vs || video_on !== e.von || frame_start !== e.fs) begin
          failures++;
          $display("FAIL sample@%0d (now %0d) got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b want x=%0d y=%0d hs=%b vs=%b von=%b fs=%b",
                   e.cyc, cyc, pixel_x, pixel_y, hsync, vsync, video_on, frame_start,
                   e.x, e.y, e.hs, e.vs, e.von, e.fs);
        end
      end
      if (cyc >= acc_lo && cyc <= acc_hi) begin
        if (!hsync)   hs_low_n++;
        if (!vsync)   vs_low_n++;
        if (video_on) von_n++;
        if (frame_start) begin
          fs_n++;
          if (last_fs >= 0) agg("frame_period", cyc - last_fs, 510);
          last_fs = cyc;
        end
      end
`ifdef VGA_SYNC_FRAME_CNT_EN
      if (fs_prev) begin
        checks++;
        if (frame_count !== fc_prev + 16'd1) begin
          failures++;
          $display("FAIL frame_count_inc got=%h want=%h", frame_count, fc_prev + 16'd1);
        end
      end
      fs_prev = frame_start;
      fc_prev = frame_count;
`endif
    end
  end

  // Stimulus: drive reset/locked and queue the expected samples.
  initial begin : stim
    int r, r2;
    rst = 1'b1; locked = 1'b0;
    repeat (3) @(negedge refclk);
    push_rst(cyc + 1);                 // rst=1, locked=0
    @(negedge refclk);
    rst = 1'b0;
    push_rst(cyc + 1);                 // only locked low still holds reset
    @(negedge refclk);
    locked = 1'b1;
    r = cyc + 1;                       // first edge out of reset
    acc_lo = r; acc_hi = r + 1019;     // exactly two frames
    // k -> (x,y) with x = k%30, y = (k/30)%17
    push(r + 0,    0,  0, 1, 1, 1, 1);
    push(r + 1,    1,  0, 1, 1, 1, 0);
    push(r + 15,  15,  0, 1, 1, 1, 0);
    push(r + 16,  16,  0, 1, 1, 0, 0);
    push(r + 19,  19,  0, 1, 1, 0, 0);
    push(r + 20,  20,  0, 0, 1, 0, 0);
    push(r + 25,  25,  0, 0, 1, 0, 0);
    push(r + 26,  26,  0, 1, 1, 0, 0);
    push(r + 29,  29,  0, 1, 1, 0, 0);
    push(r + 30,   0,  1, 1, 1, 1, 0);
    push(r + 279,  9,  9, 1, 1, 1, 0);
    push(r + 300,  0, 10, 1, 1, 0, 0);
    push(r + 320, 20, 10, 0, 1, 0, 0);
    push(r + 359, 29, 11, 1, 1, 0, 0);
    push(r + 360,  0, 12, 1, 0, 0, 0);
    push(r + 365,  5, 12, 1, 0, 0, 0);
    push(r + 380, 20, 12, 0, 0, 0, 0);
    push(r + 419, 29, 13, 1, 0, 0, 0);
    push(r + 420,  0, 14, 1, 1, 0, 0);
    push(r + 509, 29, 16, 1, 1, 0, 0);
    push(r + 510,  0,  0, 1, 1, 1, 1);
    push(r + 1020, 0,  0, 1, 1, 1, 1);
    push(r + 1528, 28, 16, 1, 1, 0, 0);

    // counters now hold (29,16): rst lands exactly on the double wrap
    wait_to(r + 1528);
    rst = 1'b1;
    push_rst(r + 1529);
    push_rst(r + 1530);
    wait_to(r + 1530);
    rst = 1'b0;
    r2 = r + 1531;
    push(r2 + 0,   0, 0, 1, 1, 1, 1);
    push(r2 + 1,   1, 0, 1, 1, 1, 0);
    push(r2 + 160, 10, 5, 1, 1, 1, 0);

    // drop locked while showing (10,5), hold it low for 5 edges
    wait_to(r2 + 160);
    locked = 1'b0;
    push_rst(r2 + 161);
    push_rst(r2 + 165);
    wait_to(r2 + 165);
    locked = 1'b1;
    push(r2 + 166,  0, 0, 1, 1, 1, 1);
    push(r2 + 167,  1, 0, 1, 1, 1, 0);
    push(r2 + 186, 20, 0, 0, 1, 0, 0);
    push(r2 + 196,  0, 1, 1, 1, 1, 0);

    wait_to(r2 + 200);
    agg("video_on_total", von_n, 320);
    agg("hsync_low_total", hs_low_n, 204);
    agg("vsync_low_total", vs_low_n, 120);
    agg("frame_start_total", fs_n, 2);
    agg("queue_leftover", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
- REQ-001: Parameter H_VISIBLE, default 640: active pixels per line.
- REQ-002: Parameter H_FRONT, default 16: horizontal front porch, in pixel clocks.
- REQ-003: Parameter H_SYNC, default 96: hsync pulse width, in pixel clocks.
- REQ-004: Parameter H_BACK, default 48: horizontal back porch, in pixel clocks.
- REQ-005: Parameter V_VISIBLE, default 480: active lines per frame.
- REQ-006: Parameter V_FRONT, default 10: vertical front porch, in lines.
- REQ-007: Parameter V_SYNC, default 2: vsync pulse width, in lines.
- REQ-008: Parameter V_BACK, default 33: vertical back porch, in lines.
- REQ-009: refclk, input, 1 bit: the only clock; 25 MHz pixel clock from the PLL outclk_0.
- REQ-010: rst, input, 1 bit: reset, synchronous and active-high.
- REQ-011: locked, input, 1 bit: PLL lock indicator; while low, the block behaves as if in reset.
- REQ-012: hsync, output, 1 bit: horizontal sync, active-low.
- REQ-013: vsync, output, 1 bit: vertical sync, active-low.
- REQ-014: video_on, output, 1 bit: high while in the visible region.
- REQ-015: pixel_x, output, 10 bits: current column.
- REQ-016: pixel_y, output, 10 bits: current row.
- REQ-017: frame_start, output, 1 bit: one-cycle pulse at pixel (0,0).
- REQ-018: frame_count, output, 16 bits: present only when VGA_SYNC_FRAME_CNT_EN is defined.

Function
- REQ-019: H_TOTAL shall equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL shall be the vertical equivalent (525); both shall be ≤1024, or elaboration fails.
- REQ-020: The internal counter h_cnt shall count 0..H_TOTAL-1, incrementing every refclk while running and wrapping from 799 to 0.
- REQ-021: The internal counter v_cnt shall increment only on an h_cnt wrap and shall wrap from 524 to 0 when h_cnt wraps at v_cnt=524.
- REQ-022: Each axis shall run a phase state machine VISIBLE→FRONT→SYNC→BACK→VISIBLE, with transitions at counter values H_VISIBLE, +H_FRONT, +H_SYNC and the wrap (and likewise for the vertical axis).
- REQ-023: All outputs shall be registered decodes of the counter state, with 1 cycle of latency; all outputs shall stay mutually aligned.
- REQ-024: hsync shall be low exactly when h_cnt is in [656,751]; vsync shall be low exactly when v_cnt is in [490,491]; the sync pulses shall be independent of each other.
- REQ-025: video_on shall be 1 exactly when h_cnt<640 and v_cnt<480.
- REQ-026: pixel_x/pixel_y shall equal h_cnt/v_cnt in all phases, including blanking.
- REQ-027: frame_start shall be 1 for exactly one cycle when the decoded position is (0,0).

Reset
- REQ-028: While rst=1 or locked=0, both counters shall be cleared to 0 and the outputs shall be hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, frame_start=0 and frame_count=0.
- REQ-029: A reset or a locked drop mid-frame shall take effect at the next refclk edge; no partial line shall be completed.
- REQ-030: On the first edge with rst=0 and locked=1, the outputs shall show (0,0) with frame_start=1 and video_on=1; counting shall then proceed.

Configuration
- REQ-031: When VGA_SYNC_FRAME_CNT_EN is defined, frame_count shall increment by 1 in the cycle after each frame_start pulse and wrap from 0xFFFF to 0x0000; it is used for animation timing.
- REQ-032: When VGA_SYNC_FRAME_CNT_EN is undefined, the frame_count port and its register shall not exist.

Structure
- REQ-033: Package vga_timing_pkg shall hold the default 640x480@60 timing constants, the phase enum (VISIBLE, FRONT, SYNC, BACK) and the counter width (10).
- REQ-034: Sub-module vga_axis_counter (counter plus phase FSM, with a wrap/enable chain) shall be instantiated twice: horizontal enabled every cycle, vertical enabled on the horizontal wrap.

Verification
- REQ-035: Release rst with locked=1 -> the next cycle shows pixel (0,0), frame_start=1, video_on=1, hsync=1 and vsync=1.
- REQ-036: Run one line -> hsync is low for exactly 96 cycles starting at pixel_x=656, and the period is 800 cycles.
- REQ-037: Run two frames -> vsync is low for 1600 cycles starting at pixel_y=490, frame_start fires every 420000 cycles, and video_on totals 307200 cycles per frame.
- REQ-038: Drop locked at pixel (300,200) for 5 cycles -> reset values appear on the next cycle, and the sequence restarts at (0,0) with frame_start after locked returns.
- REQ-039: Assert rst on the cycle of an h_cnt wrap at v_cnt=524 -> reset takes priority, and v_cnt does not show a wrap artifact.
- REQ-040: With VGA_SYNC_FRAME_CNT_EN defined, preload frame_count near 0xFFFE via forced frames -> the sequence 0xFFFE, 0xFFFF, 0x0000 is seen on successive frame_start pulses.
